// File: rtl/bslu_pkg.sv
// Shared encodings for the bit-serial logic unit: op codes, FSM states and index sizing.
package bslu_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-index width; a 1-bit unit still needs a 1-bit index signal.
    function automatic int bslu_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bslu_bitslice.sv
// Single-bit combinational slice: applies the op to one operand bit pair and flags a difference.
module bslu_bitslice
    import bslu_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a_i,
    input  logic       b_i,
    output logic       q_i,
    output logic       diff_i
);

    always_comb begin
        q_i = 1'b0;
        case (op)
            OP_NONE: q_i = 1'b0;
            OP_XOR:  q_i = a_i ^ b_i;
            OP_AND:  q_i = a_i & b_i;
            OP_OR:   q_i = a_i | b_i;
            default: q_i = 1'b0;
        endcase
    end

    assign diff_i = a_i ^ b_i;

endmodule

// File: rtl/bitserial_logic_unit.sv
// Bit-serial logic/compare unit: one bit per cycle, MSB first, fixed WIDTH-cycle run.
// Define BSLU_SIGNED_CMP_EN for a two's-complement lt result.
module bitserial_logic_unit
    import bslu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             ne,
    output logic             lt
);

    localparam int IW = bslu_idx_w(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             resolved_q, resolved_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ne_q, ne_d;
    logic             lt_q, lt_d;

    logic a_bit, b_bit, q_bit, diff_bit, lt_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    bslu_bitslice u_slice (
        .op     (op_q),
        .a_i    (a_bit),
        .b_i    (b_bit),
        .q_i    (q_bit),
        .diff_i (diff_bit)
    );

`ifdef BSLU_SIGNED_CMP_EN
    // A difference in the sign bit inverts the unsigned ordering.
    assign lt_bit = (idx_q == IW'(WIDTH - 1)) ? a_bit : b_bit;
`else
    assign lt_bit = b_bit;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        resolved_d = resolved_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        ne_d       = ne_q;
        lt_d       = lt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    res_d      = '0;
                    ne_d       = 1'b0;
                    lt_d       = 1'b0;
                    resolved_d = 1'b0;
                    idx_d      = IW'(WIDTH - 1);
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[idx_q] = q_bit;
                if (diff_bit && !resolved_q) begin
                    ne_d       = 1'b1;
                    lt_d       = lt_bit;
                    resolved_d = 1'b1;
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            resolved_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_NONE;
            res_q      <= '0;
            ne_q       <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            resolved_q <= resolved_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            ne_q       <= ne_d;
            lt_q       <= lt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign q    = res_q;
    assign ne   = ne_q;
    assign lt   = lt_q;

endmodule
